// File: rtl/clk_div_mc.sv
// Multi-channel runtime-programmable clock divider with per-channel rising-edge strobes and global sync.
// Optional CLK_DIV_ODD_HALF_EN: odd divisors get exact 50% duty via a negedge-delayed copy.
module clk_div_mc #(
  parameter int unsigned CH_NUM  = 2,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic                    i_clk,
  input  logic                    rst_n,
  input  logic [CH_NUM*CNT_W-1:0] i_div_val,
  input  logic [CH_NUM-1:0]       i_load,
  input  logic                    i_sync,
  output logic [CH_NUM-1:0]       o_clk,
  output logic [CH_NUM-1:0]       o_stb,
  output logic [CH_NUM-1:0]       o_pend
);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    return (v < CNT_W'(2)) ? CNT_W'(2) : v;
  endfunction

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] p_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] last;
    logic [CNT_W:0]   hi;
    logic             pend_q;
    logic             clk_q;
    logic             stb_q;
    logic             boundary;

    assign load_val = clamp_div(i_div_val[k*CNT_W +: CNT_W]);
    assign last     = n_q - CNT_W'(1);
    assign boundary = (cnt_q == last);

`ifdef CLK_DIV_ODD_HALF_EN
    // posedge high time is floor(N/2); the negedge copy supplies the extra half cycle for odd N
    assign hi = {1'b0, n_q >> 1};
`else
    assign hi = ({1'b0, n_q} + (CNT_W+1)'(1)) >> 1;
`endif

    always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
        n_q    <= CNT_W'(DEF_DIV);
        p_q    <= CNT_W'(DEF_DIV);
        pend_q <= 1'b0;
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        stb_q  <= 1'b0;
      end else begin
        if (i_sync) begin
          cnt_q <= '0;
          clk_q <= 1'b0;
          stb_q <= 1'b0;
          if (pend_q) n_q <= p_q;
        end else begin
          clk_q <= ({1'b0, cnt_q} < hi);
          stb_q <= (cnt_q == '0);
          cnt_q <= boundary ? '0 : cnt_q + CNT_W'(1);
          if (boundary && pend_q) n_q <= p_q;
        end
        // a load coinciding with a boundary or sync stays pending; the older value is what got applied
        if (i_load[k]) begin
          p_q    <= load_val;
          pend_q <= 1'b1;
        end else if (i_sync || boundary) begin
          pend_q <= 1'b0;
        end
      end
    end

`ifdef CLK_DIV_ODD_HALF_EN
    logic odd_q;
    logic neg_q;

    always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) odd_q <= 1'b0;
      else        odd_q <= n_q[0];
    end

    always_ff @(negedge i_clk or negedge rst_n) begin
      if (!rst_n) neg_q <= 1'b0;
      else        neg_q <= clk_q & odd_q;
    end

    assign o_clk[k] = clk_q | neg_q;
`else
    assign o_clk[k] = clk_q;
`endif
    assign o_stb[k]  = stb_q;
    assign o_pend[k] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_mc.sv
// Self-checking bench for clk_div_mc: directed and random loads/syncs against a timestamp-based period model.
module tb_clk_div_mc;
  localparam int unsigned CH  = 2;
  localparam int unsigned W   = 16;
  localparam int unsigned DEF = 2;

  logic          i_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH*W-1:0] div_val = '0;
  logic [CH-1:0] load = '0;
  logic          sync = 1'b0;
  logic [CH-1:0] o_clk, o_stb, o_pend;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  clk_div_mc #(.CH_NUM(CH), .CNT_W(W), .DEF_DIV(DEF)) dut (
    .i_clk(i_clk), .rst_n(rst_n), .i_div_val(div_val), .i_load(load),
    .i_sync(sync), .o_clk(o_clk), .o_stb(o_stb), .o_pend(o_pend)
  );

  // Model: each channel remembers the edge index of its latest rise and the divisor of the period in force.
  int unsigned m_n[CH];
  int unsigned m_p[CH];
  bit          m_pend[CH];
  int          m_rise[CH];
  bit          x_clk[CH];
  bit          x_stb[CH];
  int          e;

  function automatic int unsigned hi_of(input int unsigned n);
`ifdef CLK_DIV_ODD_HALF_EN
    return n / 2;
`else
    return (n + 1) / 2;
`endif
  endfunction

  function automatic int unsigned clampv(input int unsigned v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    e = 0;
    for (int k = 0; k < CH; k++) begin
      m_n[k] = DEF; m_p[k] = DEF; m_pend[k] = 1'b0; m_rise[k] = 0;
      x_clk[k] = 1'b0; x_stb[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < CH; k++) begin
      int ph;
      int unsigned v;
      if (sync) begin
        x_clk[k] = 1'b0;
        x_stb[k] = 1'b0;
        if (m_pend[k]) begin m_n[k] = m_p[k]; m_pend[k] = 1'b0; end
        m_rise[k] = e + 1;
      end else begin
        ph = e - m_rise[k];
        x_stb[k] = (ph == 0);
        x_clk[k] = (ph < int'(hi_of(m_n[k])));
        if (ph == int'(m_n[k]) - 1) begin
          if (m_pend[k]) begin m_n[k] = m_p[k]; m_pend[k] = 1'b0; end
          m_rise[k] = e + 1;
        end
      end
      if (load[k]) begin
        v = 32'(div_val[k*W +: W]);
        m_p[k] = clampv(v);
        m_pend[k] = 1'b1;
      end
    end
    e++;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0b exp=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    #1;
    for (int k = 0; k < CH; k++) begin
      check($sformatf("clk%0d e%0d", k, e - 1), o_clk[k], x_clk[k]);
      check($sformatf("stb%0d e%0d", k, e - 1), o_stb[k], x_stb[k]);
      check($sformatf("pend%0d e%0d", k, e - 1), o_pend[k], m_pend[k]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_ch(input int k, input int unsigned v);
    div_val[k*W +: W] = W'(v);
    load[k] = 1'b1;
    cycle();
    load[k] = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < CH; k++) begin
      check($sformatf("%s clk%0d", tag, k), o_clk[k], 1'b0);
      check($sformatf("%s stb%0d", tag, k), o_stb[k], 1'b0);
      check($sformatf("%s pend%0d", tag, k), o_pend[k], 1'b0);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    @(negedge i_clk);
    rst_n = 1'b1;
    model_reset();
    run(8);

    // divisor changes mid-period, odd divisor, clamped values
    run(1);
    load_ch(0, 6);
    run(20);
    load_ch(1, 5);
    run(20);
    load_ch(0, 0);
    run(10);
    load_ch(1, 1);
    run(10);

    // free-running 4 and 7, then sync with a pending load, then sync concurrent with a load
    load_ch(0, 4);
    load_ch(1, 7);
    run(30);
    load_ch(0, 3);
    pulse_sync();
    run(20);
    div_val[1*W +: W] = W'(9);
    load[1] = 1'b1;
    sync = 1'b1;
    cycle();
    load[1] = 1'b0;
    sync = 1'b0;
    run(30);

    // load landing exactly on the boundary edge of channel 0
    for (int i = 0; i < 200 && (e - m_rise[0]) != int'(m_n[0]) - 1; i++) cycle();
    load_ch(0, 5);
    run(25);

    // random loads and syncs
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) pulse_sync();
      else load_ch(int'($urandom_range(0, CH - 1)), $urandom_range(0, 13));
      run(int'($urandom_range(0, 15)));
    end

    // maximum divisor
    load_ch(0, 65535);
    run(65535 + 40);

    // async reset mid-period with a pending load
    load_ch(1, 11);
    run(2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge i_clk);
    rst_n = 1'b1;
    model_reset();
    run(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
